// File: rtl/interact_regbank_if.sv
// Host bridge bus into the settings register bank.
// The master drives address, strobes and write data; the bank returns registered read data.
interface interact_regbank_if;
   logic [31:0] bridge_addr;
   logic        bridge_wr;
   logic [31:0] bridge_wr_data;
   logic        bridge_rd;
   logic [31:0] bridge_rd_data;

   modport master (
      output bridge_addr, bridge_wr, bridge_wr_data, bridge_rd,
      input  bridge_rd_data
   );

   modport slave (
      input  bridge_addr, bridge_wr, bridge_wr_data, bridge_rd,
      output bridge_rd_data
   );
endinterface

// File: rtl/interact_regbank.sv
// Bridge settings register bank with per-register update strobes and a
// retriggerable core-reset pulse generator, all in the clk_74a domain.
module interact_regbank #(
   parameter int unsigned          NUM_REGS     = 16,
   parameter logic [31:0]          BASE_ADDR    = 32'hF1000000,
   parameter int unsigned          STRIDE_LOG2  = 24,
   parameter logic [31:0]          CMD_ADDR     = 32'hF0000000,
   parameter logic [NUM_REGS-1:0]  RESET_MASK   = NUM_REGS'(16'h0009),
   parameter int unsigned          RESET_CYCLES = 8000
) (
   input  logic                     clk_74a,
   input  logic                     reset,
   interact_regbank_if.slave        bridge,
   output logic [NUM_REGS*32-1:0]   regs_flat,
   output logic [NUM_REGS-1:0]      reg_upd,
   output logic                     reset_sw
);

   localparam int unsigned       CNT_W    = $clog2(RESET_CYCLES + 1);
   localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(RESET_CYCLES);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

   logic [NUM_REGS-1:0] hit_c;
   logic                cmd_hit_c;
   logic                rd_hit_c;
   logic                trigger_c;
   logic [31:0]         rd_mux_c;
   logic [CNT_W-1:0]    cnt;

   // Address decode: one exact-match comparator per register slot
   always_comb begin
      hit_c = '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         hit_c[i] = (bridge.bridge_addr == (BASE_ADDR + (32'(i) << STRIDE_LOG2)));
      end
   end

   always_comb begin
      rd_mux_c = '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         if (hit_c[i]) rd_mux_c = regs_flat[32*i +: 32];
      end
   end

   assign cmd_hit_c = (bridge.bridge_addr == CMD_ADDR);
   assign rd_hit_c  = |hit_c;
   assign trigger_c = bridge.bridge_wr && (cmd_hit_c || (|(hit_c & RESET_MASK)));

   // Register storage and update strobes; strobe coincides with the new value
   always_ff @(posedge clk_74a or posedge reset) begin
      if (reset) begin
         regs_flat <= '0;
         reg_upd   <= '0;
      end else begin
         reg_upd <= bridge.bridge_wr ? hit_c : '0;
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (bridge.bridge_wr && hit_c[i]) regs_flat[32*i +: 32] <= bridge.bridge_wr_data;
         end
      end
   end

   // Read port; unmapped reads hold the previous data
   always_ff @(posedge clk_74a or posedge reset) begin
      if (reset) begin
         bridge.bridge_rd_data <= '0;
      end else if (bridge.bridge_rd) begin
         if (rd_hit_c)       bridge.bridge_rd_data <= rd_mux_c;
         else if (cmd_hit_c) bridge.bridge_rd_data <= {31'b0, ~reset_sw};
      end
   end

   // Core-reset pulse: trigger reloads the counter, even on the expiry cycle
   always_ff @(posedge clk_74a or posedge reset) begin
      if (reset) begin
         cnt      <= CNT_LOAD;
         reset_sw <= 1'b1;
      end else if (trigger_c) begin
         cnt      <= CNT_LOAD;
         reset_sw <= 1'b1;
      end else if (cnt != '0) begin
         cnt      <= cnt - CNT_ONE;
         reset_sw <= (cnt != CNT_ONE);
      end else begin
         reset_sw <= 1'b0;
      end
   end

endmodule

// File: tb/tb_interact_regbank.sv
// Self-checking bench for interact_regbank: bank writes, decode boundaries,
// read latency/ordering via an expected-read queue, and core-reset pulse timing.
module tb_interact_regbank;

   localparam int unsigned NR       = 16;
   localparam int unsigned RC       = 8000;
   localparam logic [31:0] CMD_ADDR = 32'hF0000000;

   logic clk_74a = 1'b0;
   logic reset   = 1'b0;
   always #5 clk_74a = ~clk_74a;

   interact_regbank_if bus();
   logic [NR*32-1:0] regs_flat;
   logic [NR-1:0]    reg_upd;
   logic             reset_sw;

   interact_regbank dut (
      .clk_74a   (clk_74a),
      .reset     (reset),
      .bridge    (bus),
      .regs_flat (regs_flat),
      .reg_upd   (reg_upd),
      .reset_sw  (reset_sw)
   );

   int unsigned      n_tests = 0;
   int unsigned      n_fail  = 0;
   logic [31:0]      exp_q[$];
   logic [31:0]      model_rd   = '0;
   logic [NR*32-1:0] model_flat = '0;

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] reg_addr(input int i);
      return 32'hF1000000 + (32'(i) << 24);
   endfunction

   function automatic int map_addr(input logic [31:0] a);
      for (int i = 0; i < int'(NR); i++) if (a == reg_addr(i)) return i;
      return -1;
   endfunction

   task automatic step();
      @(posedge clk_74a);
      #1;
   endtask

   task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
      int idx;
      idx = map_addr(a);
      if (idx >= 0) model_flat[32*idx +: 32] = d;
      bus.bridge_addr    = a;
      bus.bridge_wr_data = d;
      bus.bridge_wr      = 1'b1;
      step();
      bus.bridge_wr = 1'b0;
      check("wr_upd", 512'(reg_upd), (idx >= 0) ? 512'(16'(1) << idx) : 512'(0));
      check("wr_regs", regs_flat, model_flat);
   endtask

   task automatic bus_rd(input logic [31:0] a, input logic [31:0] e);
      bus.bridge_addr = a;
      bus.bridge_rd   = 1'b1;
      exp_q.push_back(e);
      model_rd = e;
      step();
      bus.bridge_rd = 1'b0;
   endtask

   task automatic count_high(output int n);
      n = 0;
      while (reset_sw === 1'b1 && n < 20000) begin
         n++;
         step();
      end
   endtask

   // Read-data scoreboard: one expected value per read strobe
   always @(posedge clk_74a) begin
      if (bus.bridge_rd === 1'b1) begin
         #1;
         check("rd_q_nonempty", 512'(exp_q.size() != 0), 512'(1));
         if (exp_q.size() != 0) check("rd_data", 512'(bus.bridge_rd_data), 512'(exp_q.pop_front()));
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bus.bridge_addr    = '0;
      bus.bridge_wr      = 1'b0;
      bus.bridge_wr_data = '0;
      bus.bridge_rd      = 1'b0;

      // 1: reset state and post-reset pulse
      #2 reset = 1'b1;
      repeat (3) step();
      check("rst_sw", 512'(reset_sw), 512'(1));
      check("rst_regs", regs_flat, '0);
      check("rst_upd", 512'(reg_upd), 512'(0));
      check("rst_rd", 512'(bus.bridge_rd_data), 512'(0));
      reset = 1'b0;
      count_high(n);
      check("t1_pulse", 512'(n), 512'(RC));
      bus_rd(CMD_ADDR, 32'd1);

      // 2: unmasked register write
      bus_wr(reg_addr(1), 32'hDEADBEEF);
      check("t2_reg1", 512'(regs_flat[63:32]), 512'(32'hDEADBEEF));
      check("t2_sw", 512'(reset_sw), 512'(0));
      bus_rd(reg_addr(1), 32'hDEADBEEF);
      check("t2_upd_clr", 512'(reg_upd), 512'(0));
      repeat (3) step();
      check("t2_sw_late", 512'(reset_sw), 512'(0));

      // 3: masked write triggers pulse, CMD write at cycle 5000 extends it
      bus_wr(reg_addr(0), 32'h0000_0005);
      check("t3_sw_on", 512'(reset_sw), 512'(1));
      bus_rd(CMD_ADDR, 32'd0);
      repeat (4998) step();
      check("t3_sw_mid", 512'(reset_sw), 512'(1));
      bus_wr(CMD_ADDR, 32'h1234_5678);
      count_high(n);
      check("t3_total", 512'(5000 + n), 512'(13000));

      // 4: misaligned and out-of-range addresses are ignored
      bus_wr(32'hF1800000, 32'hAAAA5555);
      bus_wr(32'hF1000000 + (32'd16 << 24), 32'h5555AAAA);
      check("t4_sw", 512'(reset_sw), 512'(0));
      bus_rd(32'hF1800000, model_rd);
      bus_rd(32'hF1000000 + (32'd16 << 24), model_rd);

      // 5: same-cycle read and write returns old value
      bus_wr(reg_addr(2), 32'h11);
      model_flat[95:64] = 32'h22;
      exp_q.push_back(32'h11);
      bus.bridge_addr    = reg_addr(2);
      bus.bridge_wr_data = 32'h22;
      bus.bridge_wr      = 1'b1;
      bus.bridge_rd      = 1'b1;
      step();
      bus.bridge_wr = 1'b0;
      bus.bridge_rd = 1'b0;
      check("t5_regs", regs_flat, model_flat);
      bus_rd(reg_addr(2), 32'h22);

      // 6: async reset mid-pulse clears bank and reloads the counter
      bus_wr(reg_addr(3), 32'h33);
      repeat (100) step();
      check("t6_sw_busy", 512'(reset_sw), 512'(1));
      reset = 1'b1;
      #1;
      check("t6_regs", regs_flat, '0);
      check("t6_sw", 512'(reset_sw), 512'(1));
      check("t6_rd", 512'(bus.bridge_rd_data), 512'(0));
      model_flat = '0;
      model_rd   = '0;
      step();
      reset = 1'b0;
      count_high(n);
      check("t6_pulse", 512'(n), 512'(RC));
      bus_rd(reg_addr(3), 32'h0);
      bus_rd(CMD_ADDR, 32'd1);

      repeat (2) step();
      check("q_drained", 512'(exp_q.size()), 512'(0));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
